// File: rtl/stage_fetch.sv
// ---------------------------------------------------------------------------
// stage_fetch
//
// Fetch stage and program-counter owner for the five-stage pipeline.
// Drives a synchronous-read instruction ROM (4096 words) and fills the F/D
// latch with {instruction, pc+1}. Control-flow redirects resolved in execute
// replace the PC, squash the wrong-path words (F/D and the in-flight ROM read)
// and request a bubble in D/X. Decode-stage stalls freeze the PC, the
// in-flight fetch and F/D. Two free-running counters report useful fetches
// and accepted redirects.
//
// Ports
//   clock           rising-edge clock for all state
//   reset           asynchronous, active-high; clears all state
//   stall           hazard-unit stall; holds PC, in-flight fetch and F/D
//   redirect_valid  execute resolved a control transfer this cycle
//   redirect_pc     target PC (only meaningful with redirect_valid)
//   imem_addr       ROM address, registered inside the ROM at the edge
//   imem_data       ROM word for the address registered at the last edge
//   fd_insn         F/D instruction, forced to 0 (nop) when fd_valid=0
//   fd_pc_plus_1    F/D PC+1 of fd_insn
//   fd_pc_upper_5   fd_pc_plus_1[31:27], used for jump-target concatenation
//   fd_valid        F/D holds a real, correct-path instruction
//   flush_dx        D/X must load a bubble at this edge
//   fetch_count     number of valid instructions loaded into F/D
//   redirect_count  number of accepted redirects
// ---------------------------------------------------------------------------
module stage_fetch (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [11:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] fd_insn,
  output logic [31:0] fd_pc_plus_1,
  output logic [4:0]  fd_pc_upper_5,
  output logic        fd_valid,
  output logic        flush_dx,
  output logic [31:0] fetch_count,
  output logic [31:0] redirect_count
);

  // FILL: no valid word is in flight in the ROM (after reset or redirect).
  // RUN:  the ROM output register holds the word at r_inflightPc.
  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } fetchState_t;

  fetchState_t r_state;

  logic [31:0] r_pc;
  logic [31:0] r_inflightPc;
  logic [31:0] r_fdInsn;
  logic [31:0] r_fdPcPlus1;
  logic        r_fdValid;
  logic [31:0] r_fetchCount;
  logic [31:0] r_redirectCount;

  logic        w_inflightValid;
  logic        w_holdFetch;
  logic        w_advance;
  logic [31:0] w_pcPlus1;
  logic [31:0] w_inflightPcPlus1;

  // The in-flight word is valid exactly when the FSM is in RUN.
  assign w_inflightValid   = (r_state == RUN);

  // A redirect always wins over a stall, so a stall only holds the pipe
  // when no redirect is present; a normal advance needs neither.
  assign w_holdFetch       = stall & ~redirect_valid;
  assign w_advance         = ~stall & ~redirect_valid;

  assign w_pcPlus1         = r_pc + 32'd1;
  assign w_inflightPcPlus1 = r_inflightPc + 32'd1;

  // While held, the ROM must re-register the in-flight address: its output
  // register is overwritten at every edge, so presenting the in-flight PC
  // again is what keeps the held word available for the release edge.
  assign imem_addr = w_holdFetch ? r_inflightPc[11:0] : r_pc[11:0];

  // The bubble request follows the redirect directly, but is suppressed
  // while reset is asserted so D/X sees a quiet interface during reset.
  assign flush_dx = redirect_valid & ~reset;

  // Fetch FSM with its registered outputs. Priority is reset, then
  // redirect, then stall (hold everything), then a normal advance.
  // A redirect discards both wrong-path words: the one already in F/D and
  // the one sitting in the ROM register, hence the return to FILL and the
  // two-bubble penalty. On a normal advance the ROM word is paired with the
  // address it was fetched from, and a word fetched during FILL is turned
  // into a nop so downstream never sees stale ROM data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state         <= FILL;
      r_pc            <= '0;
      r_inflightPc    <= '0;
      r_fdInsn        <= '0;
      r_fdPcPlus1     <= '0;
      r_fdValid       <= 1'b0;
      r_fetchCount    <= '0;
      r_redirectCount <= '0;
    end else if (redirect_valid) begin
      r_state         <= FILL;
      r_pc            <= redirect_pc;
      r_fdInsn        <= '0;
      r_fdPcPlus1     <= '0;
      r_fdValid       <= 1'b0;
      r_redirectCount <= r_redirectCount + 32'd1;
    end else if (w_advance) begin
      r_state      <= RUN;
      r_fdValid    <= w_inflightValid;
      r_fdInsn     <= w_inflightValid ? imem_data : 32'd0;
      r_fdPcPlus1  <= w_inflightValid ? w_inflightPcPlus1 : 32'd0;
      r_inflightPc <= r_pc;
      r_pc         <= w_pcPlus1;
      r_fetchCount <= r_fetchCount + {31'd0, w_inflightValid};
    end
  end

  assign fd_insn        = r_fdInsn;
  assign fd_pc_plus_1   = r_fdPcPlus1;
  assign fd_pc_upper_5  = r_fdPcPlus1[31:27];
  assign fd_valid       = r_fdValid;
  assign fetch_count    = r_fetchCount;
  assign redirect_count = r_redirectCount;

endmodule

// File: tb/tb_stage_fetch.sv
// ---------------------------------------------------------------------------
// tb_stage_fetch
//
// Bench for stage_fetch. A 4096-word synchronous ROM lives here, and a
// reference model tracks, at instruction level, which PC is next to appear
// in F/D and how many bubble edges remain before it does. Each test task
// drives its own scenario and compares the DUT against the model and
// against the fixed values of that scenario.
// ---------------------------------------------------------------------------
module tb_stage_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic [11:0] imemAddr;
  logic [31:0] imemData;
  logic [31:0] fdInsn;
  logic [31:0] fdPcPlus1;
  logic [4:0]  fdPcUpper5;
  logic        fdValid;
  logic        flushDx;
  logic [31:0] fetchCount;
  logic [31:0] redirectCount;

  logic [31:0] rom [4096];

  int tests  = 0;
  int failed = 0;

  // Reference model: mExpPc is the PC of the next instruction to reach F/D,
  // mBubbles the number of normal edges that still load a bubble first.
  logic [31:0] mExpPc;
  int          mBubbles;
  logic        mFdValid;
  logic [31:0] mFdInsn;
  logic [31:0] mFdPcPlus1;
  logic [31:0] mFetchCount;
  logic [31:0] mRedirectCount;

  logic [133:0] dutVec;
  logic [133:0] modelVec;

  assign dutVec   = {fdValid, fdInsn, fdPcPlus1, fdPcUpper5, fetchCount, redirectCount};
  assign modelVec = {mFdValid, mFdInsn, mFdPcPlus1, mFdPcPlus1[31:27], mFetchCount, mRedirectCount};

  // 100 MHz-style free-running clock.
  always #5 clock = ~clock;

  // Synchronous-read instruction ROM.
  always @(posedge clock) imemData <= rom[imemAddr];

  stage_fetch dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirectValid),
    .redirect_pc    (redirectPc),
    .imem_addr      (imemAddr),
    .imem_data      (imemData),
    .fd_insn        (fdInsn),
    .fd_pc_plus_1   (fdPcPlus1),
    .fd_pc_upper_5  (fdPcUpper5),
    .fd_valid       (fdValid),
    .flush_dx       (flushDx),
    .fetch_count    (fetchCount),
    .redirect_count (redirectCount)
  );

  // ROM holds 0x1000_0000 + address, so every word names its own location.
  task automatic fillPattern();
    for (int i = 0; i < 4096; i++) rom[i] = 32'h1000_0000 + 32'(i);
  endtask

  task automatic fillRandom();
    for (int i = 0; i < 4096; i++) rom[i] = $urandom;
  endtask

  // After reset the first fetched word (PC 0) shows up one bubble later.
  task automatic modelReset();
    mExpPc         = 32'd0;
    mBubbles       = 1;
    mFdValid       = 1'b0;
    mFdInsn        = 32'd0;
    mFdPcPlus1     = 32'd0;
    mFetchCount    = 32'd0;
    mRedirectCount = 32'd0;
  endtask

  // One clock edge of the pipeline, from the spec rules: a redirect costs
  // this edge plus one more bubble, a stall freezes everything, otherwise
  // either a bubble drains or the next sequential instruction arrives.
  task automatic modelEdge();
    if (redirectValid) begin
      mFdValid       = 1'b0;
      mFdInsn        = 32'd0;
      mFdPcPlus1     = 32'd0;
      mExpPc         = redirectPc;
      mBubbles       = 1;
      mRedirectCount = mRedirectCount + 32'd1;
    end else if (!stall) begin
      if (mBubbles > 0) begin
        mFdValid   = 1'b0;
        mFdInsn    = 32'd0;
        mFdPcPlus1 = 32'd0;
        mBubbles   = mBubbles - 1;
      end else begin
        mFdValid    = 1'b1;
        mFdInsn     = rom[mExpPc[11:0]];
        mFdPcPlus1  = mExpPc + 32'd1;
        mExpPc      = mExpPc + 32'd1;
        mFetchCount = mFetchCount + 32'd1;
      end
    end
  endtask

  // Advance one edge; returns 1 time unit after the edge.
  task automatic clockEdge();
    @(posedge clock);
    modelEdge();
    #1;
  endtask

  task automatic applyReset();
    reset         = 1'b1;
    stall         = 1'b0;
    redirectValid = 1'b0;
    redirectPc    = 32'd0;
    #20;
    modelReset();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    redirectValid = 1'b1;
    redirectPc    = 32'h0000_1234;
    stall         = 1'b0;
    #1;
    tests++;
    if (dutVec !== 134'd0) begin
      failed++;
      $display("[TB] FAIL reset_state: got %h expected 0", dutVec);
    end
    tests++;
    if (imemAddr !== 12'd0) begin
      failed++;
      $display("[TB] FAIL reset_imem_addr: got %h expected 000", imemAddr);
    end
    tests++;
    if (flushDx !== 1'b0) begin
      failed++;
      $display("[TB] FAIL reset_flush_gate: got %b expected 0", flushDx);
    end
    applyReset();
  endtask

  task automatic test_sequential();
    fillPattern();
    applyReset();
    for (int k = 1; k <= 4; k++) begin
      #1;
      tests++;
      if (imemAddr !== 12'(k - 1)) begin
        failed++;
        $display("[TB] FAIL seq_imem_addr[%0d]: got %h expected %h", k, imemAddr, 12'(k - 1));
      end
      clockEdge();
      tests++;
      if (dutVec !== modelVec) begin
        failed++;
        $display("[TB] FAIL seq_state[%0d]: got %h expected %h", k, dutVec, modelVec);
      end
    end
    tests++;
    if (fdInsn !== 32'h1000_0002 || fdPcPlus1 !== 32'd3 || fdValid !== 1'b1 || fetchCount !== 32'd3) begin
      failed++;
      $display("[TB] FAIL seq_edge4: got insn=%h pc1=%h v=%b cnt=%0d expected insn=10000002 pc1=3 v=1 cnt=3",
               fdInsn, fdPcPlus1, fdValid, fetchCount);
    end
  endtask

  task automatic test_redirect();
    fillPattern();
    applyReset();
    for (int k = 0; k < 6; k++) clockEdge();
    tests++;
    if (fdPcPlus1 !== 32'd5) begin
      failed++;
      $display("[TB] FAIL redir_setup: got pc1=%h expected 5", fdPcPlus1);
    end
    redirectValid = 1'b1;
    redirectPc    = 32'h0000_0040;
    #1;
    tests++;
    if (flushDx !== 1'b1) begin
      failed++;
      $display("[TB] FAIL redir_flush: got %b expected 1", flushDx);
    end
    clockEdge();
    redirectValid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (dutVec !== modelVec || fdValid !== 1'b0) begin
        failed++;
        $display("[TB] FAIL redir_bubble[%0d]: got %h expected %h", k, dutVec, modelVec);
      end
      clockEdge();
    end
    tests++;
    if (fdInsn !== 32'h1000_0040 || fdPcPlus1 !== 32'h41 || fdValid !== 1'b1 || redirectCount !== 32'd1) begin
      failed++;
      $display("[TB] FAIL redir_target: got insn=%h pc1=%h v=%b rc=%0d expected insn=10000040 pc1=41 v=1 rc=1",
               fdInsn, fdPcPlus1, fdValid, redirectCount);
    end
  endtask

  task automatic test_stall();
    fillPattern();
    applyReset();
    for (int k = 0; k < 8; k++) clockEdge();
    tests++;
    if (fdPcPlus1 !== 32'd7) begin
      failed++;
      $display("[TB] FAIL stall_setup: got pc1=%h expected 7", fdPcPlus1);
    end
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++;
      if (imemAddr !== 12'd7) begin
        failed++;
        $display("[TB] FAIL stall_imem_addr[%0d]: got %h expected 007", k, imemAddr);
      end
      clockEdge();
      tests++;
      if (dutVec !== modelVec || fdPcPlus1 !== 32'd7 || fdInsn !== 32'h1000_0006) begin
        failed++;
        $display("[TB] FAIL stall_hold[%0d]: got %h expected %h", k, dutVec, modelVec);
      end
    end
    stall = 1'b0;
    for (int k = 0; k < 2; k++) begin
      clockEdge();
      tests++;
      if (fdPcPlus1 !== 32'(8 + k) || fdInsn !== 32'h1000_0007 + 32'(k) || dutVec !== modelVec) begin
        failed++;
        $display("[TB] FAIL stall_resume[%0d]: got %h expected %h", k, dutVec, modelVec);
      end
    end
  endtask

  task automatic test_stall_redirect();
    fillPattern();
    applyReset();
    for (int k = 0; k < 5; k++) clockEdge();
    stall         = 1'b1;
    redirectValid = 1'b1;
    redirectPc    = 32'h0000_0010;
    #1;
    tests++;
    if (flushDx !== 1'b1) begin
      failed++;
      $display("[TB] FAIL stallredir_flush: got %b expected 1", flushDx);
    end
    clockEdge();
    stall         = 1'b0;
    redirectValid = 1'b0;
    tests++;
    if (fdValid !== 1'b0 || redirectCount !== 32'd1 || dutVec !== modelVec) begin
      failed++;
      $display("[TB] FAIL stallredir_taken: got %h expected %h", dutVec, modelVec);
    end
    clockEdge();
    clockEdge();
    tests++;
    if (fdInsn !== 32'h1000_0010 || fdPcPlus1 !== 32'h11 || fdValid !== 1'b1) begin
      failed++;
      $display("[TB] FAIL stallredir_target: got insn=%h pc1=%h v=%b expected insn=10000010 pc1=11 v=1",
               fdInsn, fdPcPlus1, fdValid);
    end
  endtask

  task automatic test_wrap();
    fillPattern();
    applyReset();
    for (int k = 0; k < 3; k++) clockEdge();
    redirectValid = 1'b1;
    redirectPc    = 32'hFFFF_FFFF;
    clockEdge();
    redirectValid = 1'b0;
    #1;
    tests++;
    if (imemAddr !== 12'hFFF) begin
      failed++;
      $display("[TB] FAIL wrap_addr_fff: got %h expected fff", imemAddr);
    end
    clockEdge();
    #1;
    tests++;
    if (imemAddr !== 12'h000) begin
      failed++;
      $display("[TB] FAIL wrap_addr_000: got %h expected 000", imemAddr);
    end
    clockEdge();
    tests++;
    if (fdPcPlus1 !== 32'd0 || fdPcUpper5 !== 5'd0 || fdInsn !== 32'h1000_0FFF || fdValid !== 1'b1
        || dutVec !== modelVec) begin
      failed++;
      $display("[TB] FAIL wrap_fd: got %h expected %h", dutVec, modelVec);
    end
  endtask

  task automatic test_async_reset();
    fillPattern();
    applyReset();
    for (int k = 0; k < 3; k++) clockEdge();
    redirectValid = 1'b1;
    redirectPc    = 32'h0000_0100;
    clockEdge();
    redirectValid = 1'b0;
    for (int k = 0; k < 3; k++) clockEdge();
    #2;
    reset         = 1'b1;
    redirectValid = 1'b1;
    #1;
    tests++;
    if (dutVec !== 134'd0 || imemAddr !== 12'd0 || flushDx !== 1'b0) begin
      failed++;
      $display("[TB] FAIL async_reset: got state=%h addr=%h flush=%b expected all 0", dutVec, imemAddr, flushDx);
    end
    #1;
    reset         = 1'b0;
    redirectValid = 1'b0;
    modelReset();
    #1;
    for (int k = 1; k <= 4; k++) begin
      clockEdge();
      tests++;
      if (dutVec !== modelVec) begin
        failed++;
        $display("[TB] FAIL async_repeat[%0d]: got %h expected %h", k, dutVec, modelVec);
      end
    end
    tests++;
    if (fdInsn !== 32'h1000_0002 || fdPcPlus1 !== 32'd3 || fetchCount !== 32'd3 || redirectCount !== 32'd0) begin
      failed++;
      $display("[TB] FAIL async_repeat_end: got insn=%h pc1=%h cnt=%0d rc=%0d expected insn=10000002 pc1=3 cnt=3 rc=0",
               fdInsn, fdPcPlus1, fetchCount, redirectCount);
    end
  endtask

  task automatic test_random();
    logic [31:0] expAddr;
    int          sel;
    fillRandom();
    applyReset();
    for (int k = 0; k < 600; k++) begin
      stall         = ($urandom_range(0, 3) == 0);
      redirectValid = ($urandom_range(0, 9) == 0);
      sel           = int'($urandom_range(0, 3));
      if (sel == 0)      redirectPc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else if (sel == 1) redirectPc = 32'h0000_0FF0 + 32'($urandom_range(0, 31));
      else               redirectPc = $urandom;
      #1;
      tests++;
      if (flushDx !== redirectValid) begin
        failed++;
        $display("[TB] FAIL rnd_flush[%0d]: got %b expected %b", k, flushDx, redirectValid);
      end
      if (stall && !redirectValid) begin
        if (mBubbles == 0) begin
          tests++;
          if (imemAddr !== mExpPc[11:0]) begin
            failed++;
            $display("[TB] FAIL rnd_hold_addr[%0d]: got %h expected %h", k, imemAddr, mExpPc[11:0]);
          end
        end
      end else begin
        expAddr = (mBubbles == 0) ? mExpPc + 32'd1 : mExpPc;
        tests++;
        if (imemAddr !== expAddr[11:0]) begin
          failed++;
          $display("[TB] FAIL rnd_addr[%0d]: got %h expected %h", k, imemAddr, expAddr[11:0]);
        end
      end
      clockEdge();
      tests++;
      if (dutVec !== modelVec) begin
        failed++;
        $display("[TB] FAIL rnd_state[%0d]: got %h expected %h", k, dutVec, modelVec);
      end
    end
    stall         = 1'b0;
    redirectValid = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    stall         = 1'b0;
    redirectValid = 1'b0;
    redirectPc    = 32'd0;
    fillPattern();
    modelReset();
    @(posedge clock);
    #1;
    test_reset();
    test_sequential();
    test_redirect();
    test_stall();
    test_stall_redirect();
    test_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/stage_fetch.md
# stage_fetch

Fetch stage and PC owner for the five-stage pipeline. It drives a synchronous-read instruction ROM and fills the F/D latch with {insn, pc_plus_1}. It accepts control-flow redirects (taken branch, j/jal/jr, taken bex) resolved in the execute stage, and squashes wrong-path instructions by invalidating F/D and asserting a D/X flush. It also honours decode-stage stalls and keeps fetch/redirect performance counters.

## Interface
- No parameters. Instruction ROM depth is fixed at 4096 words (12-bit address).
- clock  in  1  rising-edge clock for all state.
- reset  in  1  asynchronous, active-high; clears all state.
- stall  in  1  hazard-unit stall; holds PC, in-flight fetch and F/D.
- redirect_valid  in  1  execute stage resolved a control transfer this cycle.
- redirect_pc  in  32  target PC; meaningful only when redirect_valid=1.
- imem_addr  out  12  ROM address, registered by the ROM at the rising edge.
- imem_data  in  32  ROM data for the address registered at the previous edge.
- fd_insn  out  32  F/D instruction; 0 (nop) whenever fd_valid=0.
- fd_pc_plus_1  out  32  F/D PC+1 of fd_insn.
- fd_pc_upper_5  out  5  fd_pc_plus_1[31:27]; feeds jump-target concatenation.
- fd_valid  out  1  F/D holds a real, correct-path instruction.
- flush_dx  out  1  D/X latch must load a bubble at this edge.
- fetch_count  out  32  count of valid instructions loaded into F/D.
- redirect_count  out  32  count of accepted redirects.

## Operation
- State: pc (32), inflight_pc (32), inflight_valid, the F/D registers, and two counters.
- FSM states (encoded by inflight_valid):
  - FILL: inflight_valid=0.
  - RUN: inflight_valid=1.
  - Transitions: reset → FILL. FILL → RUN at any non-stall, non-redirect edge. Any state → FILL on redirect.
- imem_addr is combinational: inflight_pc[11:0] when (stall & ~redirect_valid), else pc[11:0]. During a stall the ROM therefore re-reads the in-flight word, so it is not lost.
- Edge with redirect_valid=1 (overrides stall):
  - pc ← redirect_pc; inflight_valid ← 0.
  - fd_valid ← 0, fd_insn ← 0, fd_pc_plus_1 ← 0.
  - redirect_count += 1.
- Edge with stall=1, redirect_valid=0: all state holds and counters hold.
- Normal edge (stall=0, redirect_valid=0):
  - F/D loads {imem_data, inflight_pc+1, inflight_valid}.
  - If inflight_valid=0, fd_insn ← 0 and fd_pc_plus_1 ← 0 instead.
  - inflight_pc ← pc; inflight_valid ← 1; pc ← pc+1.
  - fetch_count += inflight_valid.
- flush_dx = redirect_valid & ~reset (combinational).
- Arithmetic: pc and fd_pc_plus_1 are 32-bit modulo 2^32 (0xFFFFFFFF+1 = 0). imem_addr takes the low 12 bits, so it wraps 4095 → 0. Counters wrap at 2^32.
- No sign/range checking of redirect_pc; the execute stage computes it completely.

## Timing
- Reset values:
  - pc=0, inflight_pc=0, inflight_valid=0.
  - fd_insn=0, fd_pc_plus_1=0, fd_valid=0, fd_pc_upper_5=0.
  - fetch_count=0, redirect_count=0.
  - Outputs: flush_dx=0, imem_addr=0.
- Reset asserted mid-operation clears immediately, without waiting for a clock edge. The in-flight fetch and F/D contents are discarded.
- Fetch latency: an address presented at edge N appears in F/D after edge N+1.
  - After reset release, the first valid F/D (insn[0], pc_plus_1=1) appears after the 2nd rising edge.
- Redirect penalty: redirect at edge E gives a bubble in F/D after E and after E+1. insn[target] is in F/D after E+2, with fd_valid=1.
- Back-to-back redirects: each is accepted and each restarts FILL. redirect_count increments per edge.
- Stall during FILL keeps FILL. Stall during RUN: on release, the held word is loaded into F/D unchanged and sequential fetch resumes.
- Simultaneous stall and redirect: the redirect is taken, and stall is ignored for that edge.

## Test plan
- Reset release, ROM[i]=0x1000_0000+i, no stall/redirect:
  - F/D sequence after edges 2,3,4 is (0x10000000,1), (0x10000001,2), (0x10000002,3), with fd_valid=1.
  - fetch_count=3 after edge 4.
- Redirect to 0x40 while fd_pc_plus_1=5:
  - flush_dx=1 that cycle.
  - fd_valid=0 for 2 edges, then fd_insn=ROM[0x40] with fd_pc_plus_1=0x41.
  - redirect_count=1.
- Stall held 3 cycles while in RUN with fd_pc_plus_1=7:
  - F/D stays constant and imem_addr=7 during the stall.
  - After release the F/D sequence continues 8, 9 with no skip or duplicate.
- Stall and redirect_valid (target 0x10) asserted together:
  - Redirect wins and flush_dx=1.
  - F/D gets ROM[0x10] after 2 further edges.
- redirect_pc=0xFFFFFFFF:
  - F/D gets fd_pc_plus_1=0x00000000, fd_pc_upper_5=0, insn from ROM[0xFFF].
  - The next fetch is from imem_addr=0.
- Async reset pulsed between edges mid-stream:
  - All outputs read zero before the next edge.
  - The reset-release sequence then repeats exactly as in the first scenario.
